// File: rtl/ls_pkg.sv
// -----------------------------------------------------------------------------
// ls_pkg
// Shared types and constants for the life-support sequencer.
//   state_e      : sequencer states (3-bit encoding, also the debug `state` code)
//   MODE_*       : 4-bit mode codes driven to the life-support datapath
//   *_DEF        : default thresholds and timing constants
//   CNT_W        : width of the dwell/window/cooldown counters
//   mode_of()    : state -> mode code mapping
// -----------------------------------------------------------------------------
package ls_pkg;

  typedef enum logic [2:0] {
    ST_NORMAL   = 3'd0,
    ST_DEFENSE  = 3'd1,
    ST_STEALTH  = 3'd2,
    ST_RECHARGE = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_e;

  localparam logic [3:0] MODE_NORMAL   = 4'b0000;
  localparam logic [3:0] MODE_DEFENSE  = 4'b0100;
  localparam logic [3:0] MODE_STEALTH  = 4'b1000;
  localparam logic [3:0] MODE_RECHARGE = 4'b0001;
  localparam logic [3:0] MODE_LOCKOUT  = 4'b0000;

  localparam int unsigned N_DEF         = 32;
  localparam int unsigned PWR_LOW_DEF   = 16;
  localparam int unsigned O2_LOW_DEF    = 50;
  localparam int unsigned O2_COOL_DEF   = 8;
  localparam int unsigned TEMP_MAX_DEF  = 90;
  localparam int unsigned MIN_DWELL_DEF = 4;
  localparam int unsigned CHRG_CYC_DEF  = 6;

  // Wide enough for every reload value above with headroom.
  localparam int unsigned CNT_W = 8;

  function automatic logic [3:0] mode_of(state_e s);
    logic [3:0] m;
    case (s)
      ST_DEFENSE:  m = MODE_DEFENSE;
      ST_STEALTH:  m = MODE_STEALTH;
      ST_RECHARGE: m = MODE_RECHARGE;
      ST_LOCKOUT:  m = MODE_LOCKOUT;
      default:     m = MODE_NORMAL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/life_support_sched_if.sv
// -----------------------------------------------------------------------------
// life_support_sched_if
// Bundles the console/sensor inputs and the control outputs of the sequencer.
// There is no valid/ready handshake on this bus: requests, attack, fatal and
// the sensor buses are levels sampled every rising clock edge; chrg and o2sup
// are single-cycle strobes; mode, alarm and state are registered levels.
//   slave  : the sequencer (life_support_sched)
//   master : the console / life-support side driving requests and sensors
// -----------------------------------------------------------------------------
interface life_support_sched_if #(
  parameter int unsigned N = 32
) ();

  logic         req_def;
  logic         req_sth;
  logic         atk;
  logic         fatal;
  logic [N-1:0] power;
  logic [N-1:0] o2;
  logic [N-1:0] temp;
  logic [3:0]   mode;
  logic         chrg;
  logic         o2sup;
  logic         alarm;
  logic [2:0]   state;

  modport slave (
    input  req_def, req_sth, atk, fatal, power, o2, temp,
    output mode, chrg, o2sup, alarm, state
  );

  modport master (
    output req_def, req_sth, atk, fatal, power, o2, temp,
    input  mode, chrg, o2sup, alarm, state
  );

endinterface

// File: rtl/dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Loadable down counter that saturates at zero.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset (count -> 0)
//   load_i     : load load_val_i this cycle (wins over decrement)
//   load_val_i : reload value
//   zero_o     : count is zero
// The counter decrements every cycle it is non-zero and not being loaded.
// -----------------------------------------------------------------------------
module dwell_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/life_support_sched.sv
// -----------------------------------------------------------------------------
// life_support_sched
// Priority sequencer for the life-support datapath control pins.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : life_support_sched_if.slave
//          in : req_def, req_sth, atk, fatal, power, o2, temp
//          out: mode, chrg (recharge strobe), o2sup (O2 strobe),
//               alarm (sticky fatal), state (debug state code)
// All outputs are registered: the inputs sampled at an edge determine the
// outputs visible right after that edge.
// -----------------------------------------------------------------------------
module life_support_sched
  import ls_pkg::*;
#(
  parameter int unsigned N         = N_DEF,
  parameter int unsigned PWR_LOW   = PWR_LOW_DEF,
  parameter int unsigned O2_LOW    = O2_LOW_DEF,
  parameter int unsigned O2_COOL   = O2_COOL_DEF,
  parameter int unsigned TEMP_MAX  = TEMP_MAX_DEF,
  parameter int unsigned MIN_DWELL = MIN_DWELL_DEF,
  parameter int unsigned CHRG_CYC  = CHRG_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  life_support_sched_if.slave bus
);

  localparam logic [N-1:0]     PWR_LOW_V  = N'(PWR_LOW);
  localparam logic [N-1:0]     O2_LOW_V   = N'(O2_LOW);
  localparam logic [N-1:0]     TEMP_MAX_V = N'(TEMP_MAX);
  localparam logic [CNT_W-1:0] DEF_RELOAD  = CNT_W'(MIN_DWELL - 1);
  localparam logic [CNT_W-1:0] CHG_RELOAD  = CNT_W'(CHRG_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_RELOAD = CNT_W'(O2_COOL - 1);

  state_e     state_q, state_d;
  logic [3:0] mode_q, mode_d;
  logic       chrg_q, chrg_d;
  logic       o2sup_q, o2sup_d;
  logic       alarm_q, alarm_d;
  // Set when STEALTH is aborted on temperature while req_sth is still held;
  // blocks re-entry until the console drops req_sth and asks again.
  logic       sth_lock_q, sth_lock_d;

  logic def_load, chg_load, cool_load;
  logic def_zero, chg_zero, cool_zero;

  logic pwr_low, o2_low, hot, def_req;

  assign pwr_low = (bus.power < PWR_LOW_V);
  assign o2_low  = (bus.o2 < O2_LOW_V);
  assign hot     = (bus.temp >= TEMP_MAX_V);
  assign def_req = bus.atk | bus.req_def;

  dwell_timer #(.W(CNT_W)) u_def_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (def_load),
    .load_val_i (DEF_RELOAD),
    .zero_o     (def_zero)
  );

  dwell_timer #(.W(CNT_W)) u_chg_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (chg_load),
    .load_val_i (CHG_RELOAD),
    .zero_o     (chg_zero)
  );

  dwell_timer #(.W(CNT_W)) u_cool_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cool_load),
    .load_val_i (COOL_RELOAD),
    .zero_o     (cool_zero)
  );

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_NORMAL;
      mode_q     <= MODE_NORMAL;
      chrg_q     <= 1'b0;
      o2sup_q    <= 1'b0;
      alarm_q    <= 1'b0;
      sth_lock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      chrg_q     <= chrg_d;
      o2sup_q    <= o2sup_d;
      alarm_q    <= alarm_d;
      sth_lock_q <= sth_lock_d;
    end
  end

  // Next-state priority: fatal > low power > defense request > stealth.
  always_comb begin : next_state
    state_d    = state_q;
    def_load   = 1'b0;
    chg_load   = 1'b0;
    sth_lock_d = bus.req_sth ? sth_lock_q : 1'b0;
    case (state_q)
      ST_LOCKOUT: begin
        state_d = ST_LOCKOUT;
      end
      ST_RECHARGE: begin
        // The window always runs to completion; only fatal can cut it short.
        if (bus.fatal) begin
          state_d = ST_LOCKOUT;
        end else if (chg_zero) begin
          if (pwr_low) begin
            chg_load = 1'b1;
          end else begin
            state_d = ST_NORMAL;
          end
        end
      end
      ST_DEFENSE: begin
        if (bus.fatal) begin
          state_d = ST_LOCKOUT;
        end else if (pwr_low) begin
          state_d  = ST_RECHARGE;
          chg_load = 1'b1;
        end else if (def_req) begin
          def_load = 1'b1;
        end else if (def_zero) begin
          state_d = ST_NORMAL;
        end
      end
      ST_STEALTH: begin
        if (bus.fatal) begin
          state_d = ST_LOCKOUT;
        end else if (pwr_low) begin
          state_d  = ST_RECHARGE;
          chg_load = 1'b1;
        end else if (def_req) begin
          state_d  = ST_DEFENSE;
          def_load = 1'b1;
        end else if (hot) begin
          state_d    = ST_NORMAL;
          sth_lock_d = bus.req_sth;
        end else if (!bus.req_sth) begin
          state_d = ST_NORMAL;
        end
      end
      default: begin
        if (bus.fatal) begin
          state_d = ST_LOCKOUT;
        end else if (pwr_low) begin
          state_d  = ST_RECHARGE;
          chg_load = 1'b1;
        end else if (def_req) begin
          state_d  = ST_DEFENSE;
          def_load = 1'b1;
        end else if (bus.req_sth && !sth_lock_q) begin
          state_d = ST_STEALTH;
        end
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin : output_decode
    mode_d    = mode_of(state_d);
    alarm_d   = (state_d == ST_LOCKOUT);
    // chrg marks the first cycle of every recharge window.
    chrg_d    = chg_load;
    // O2 refill runs regardless of state, paced by its own cooldown.
    o2sup_d   = o2_low && cool_zero;
    cool_load = o2sup_d;
  end

  assign bus.mode  = mode_q;
  assign bus.chrg  = chrg_q;
  assign bus.o2sup = o2sup_q;
  assign bus.alarm = alarm_q;
  assign bus.state = state_q;

endmodule
